score_link_tx: RTL and testbench

Serial transmitter for the two-board duel link. It sends the local player's game state (score, ammunition, game phase) to the opponent board as fixed-format UART frames; the opponent's receiver side supplies the enemy score that the game display currently holds constant. It sits beside the game-control top. It takes `my_score`, `bullets_left`, `bullets_in_magazine` and the three phase enables from game logic and the FSM, and it drives a single TX pin.

---
 rtl/vga_pkg.sv | 57 +++++
 rtl/uart_tx_byte.sv | 96 +++++++++
 rtl/score_link_tx.sv | 164 ++++++++++++++++
 tb/tb_score_link_tx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the duel-link score frames (transmitter and the
// future receiver). When SCORE_LINK_CHECKSUM_EN is defined, frames carry a
// fifth checksum byte; otherwise they are four bytes long.
package vga_pkg;

  // First byte of every score-link frame
  localparam logic [7:0] SCORE_LINK_HEADER = 8'hA5;

  // Game phase carried in the top two bits of byte B3
  typedef enum logic [1:0] {
    PHASE_START = 2'b00,
    PHASE_GAME  = 2'b01,
    PHASE_END   = 2'b10
  } link_phase_t;

`ifdef SCORE_LINK_CHECKSUM_EN
  localparam int unsigned SCORE_LINK_FRAME_BYTES = 32'd5;
`else
  localparam int unsigned SCORE_LINK_FRAME_BYTES = 32'd4;
`endif

  // Frame length in UART bit-times (start + 8 data + stop per byte)
  localparam int unsigned SCORE_LINK_FRAME_BITS = SCORE_LINK_FRAME_BYTES * 32'd10;

  // 19-bit state word: the frame content that gets compared against the last frame
  typedef struct packed {
    link_phase_t phase;
    logic [6:0]  score;
    logic [6:0]  bullets;
    logic [2:0]  magazine;
  } link_state_t;

  // Phase encoding with priority end > game > start
  function automatic link_phase_t link_phase(input logic start_en,
                                             input logic game_en,
                                             input logic end_en);
    link_phase_t ph;
    if (end_en) begin
      ph = PHASE_END;
    end else if (game_en) begin
      ph = PHASE_GAME;
    end else if (start_en) begin
      ph = PHASE_START;
    end else begin
      ph = PHASE_START;
    end
    return ph;
  endfunction

  // XOR checksum over the three payload bytes
  function automatic logic [7:0] link_checksum(input logic [7:0] b1,
                                               input logic [7:0] b2,
                                               input logic [7:0] b3);
    return b1 ^ b2 ^ b3;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer, LSB first, idle high.
// `done` is high during the final cycle of the stop bit; a `start` seen in
// that same cycle begins the next byte with no idle gap.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 564
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 32'd1) ? $clog2(CLKS_PER_BIT) : 32'd1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 32'd1);
  localparam logic [CW-1:0] CYC_PRE  = CW'(CLKS_PER_BIT - 32'd2);
  localparam logic [3:0]    BIT_LAST_DATA = 4'd8;
  localparam logic [3:0]    BIT_STOP      = 4'd9;

  logic          active_r;
  logic [3:0]    bit_cnt_r;
  logic [CW-1:0] cyc_cnt_r;
  logic [7:0]    shift_r;
  logic          tx_r;
  logic          done_r;

  logic          bit_end_s;
  logic          byte_end_s;
  logic          load_s;

  // Decode bit/byte boundaries and whether a new byte is accepted this cycle
  always_comb begin
    bit_end_s  = 1'b0;
    byte_end_s = 1'b0;
    load_s     = 1'b0;
    if (active_r) begin
      bit_end_s  = (cyc_cnt_r == CYC_LAST);
      byte_end_s = (cyc_cnt_r == CYC_LAST) && (bit_cnt_r == BIT_STOP);
    end else begin
      bit_end_s  = 1'b0;
      byte_end_s = 1'b0;
    end
    if (start && (!active_r || byte_end_s)) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
  end

  // Bit timing, shift register and registered line output
  always_ff @(posedge clk) begin
    if (rst) begin
      active_r  <= 1'b0;
      bit_cnt_r <= 4'd0;
      cyc_cnt_r <= '0;
      shift_r   <= 8'h00;
      tx_r      <= 1'b1;
      done_r    <= 1'b0;
    end else begin
      // Raised one cycle early so it coincides with the last stop-bit cycle
      done_r <= active_r && (bit_cnt_r == BIT_STOP) && (cyc_cnt_r == CYC_PRE);
      if (load_s) begin
        active_r  <= 1'b1;
        bit_cnt_r <= 4'd0;
        cyc_cnt_r <= '0;
        shift_r   <= data;
        tx_r      <= 1'b0;
      end else if (active_r) begin
        if (bit_end_s) begin
          cyc_cnt_r <= '0;
          if (bit_cnt_r == BIT_STOP) begin
            active_r  <= 1'b0;
            bit_cnt_r <= 4'd0;
            tx_r      <= 1'b1;
          end else if (bit_cnt_r == BIT_LAST_DATA) begin
            bit_cnt_r <= bit_cnt_r + 4'd1;
            tx_r      <= 1'b1;
          end else begin
            bit_cnt_r <= bit_cnt_r + 4'd1;
            tx_r      <= shift_r[0];
            shift_r   <= {1'b0, shift_r[7:1]};
          end
        end else begin
          cyc_cnt_r <= cyc_cnt_r + 1'b1;
        end
      end else begin
        tx_r <= 1'b1;
      end
    end
  end

  assign tx   = tx_r;
  assign done = done_r;

endmodule

// File: rtl/score_link_tx.sv
// Duel-link transmitter: sends {header, score, bullets, phase|magazine}
// frames whenever the local game state changes, plus one announce frame
// after reset. Optional macro SCORE_LINK_CHECKSUM_EN appends an XOR
// checksum byte.
module score_link_tx
  import vga_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 564,
  parameter logic [7:0]  HEADER       = SCORE_LINK_HEADER
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] my_score,
  input  logic [6:0] bullets_left,
  input  logic [2:0] bullets_in_magazine,
  input  logic       start_screen_enable,
  input  logic       game_enable,
  input  logic       game_end_enable,
  output logic       tx,
  output logic       busy,
  output logic       frame_sent
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_SEND_BYTE = 3'd2;
  localparam logic [2:0] ST_WAIT_BYTE = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  localparam logic [2:0] LAST_BYTE = 3'(SCORE_LINK_FRAME_BYTES - 32'd1);

  link_state_t cur_s;
  link_state_t snap_r;
  link_state_t last_sent_r;

  logic [2:0]  state_r;
  logic [2:0]  state_nxt_s;
  logic [2:0]  byte_idx_r;
  logic [2:0]  byte_sel_s;
  logic        force_send_r;
  logic        busy_r;
  logic        frame_sent_r;

  logic        start_s;
  logic        frame_end_s;
  logic [7:0]  byte_data_s;
  logic        byte_done_s;
  logic        tx_s;

  // Assemble the live state word from game inputs
  always_comb begin
    cur_s          = '0;
    cur_s.phase    = link_phase(start_screen_enable, game_enable, game_end_enable);
    cur_s.score    = my_score;
    cur_s.bullets  = bullets_left;
    cur_s.magazine = bullets_in_magazine;
  end

  // Frame FSM next state, serializer start strobe and next-byte selection
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    frame_end_s = 1'b0;
    byte_sel_s  = byte_idx_r;
    case (state_r)
      ST_IDLE: begin
        if (force_send_r || (cur_s != last_sent_r)) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Header does not depend on the snapshot, so it can start right away
        start_s     = 1'b1;
        byte_sel_s  = 3'd0;
        state_nxt_s = ST_SEND_BYTE;
      end
      ST_SEND_BYTE: begin
        state_nxt_s = ST_WAIT_BYTE;
      end
      ST_WAIT_BYTE: begin
        if (byte_done_s) begin
          if (byte_idx_r == LAST_BYTE) begin
            frame_end_s = 1'b1;
            state_nxt_s = ST_DONE;
          end else begin
            start_s     = 1'b1;
            byte_sel_s  = byte_idx_r + 3'd1;
            state_nxt_s = ST_SEND_BYTE;
          end
        end else begin
          state_nxt_s = ST_WAIT_BYTE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Byte mux: payload bytes come from the snapshot only
  always_comb begin
    byte_data_s = HEADER;
    case (byte_sel_s)
      3'd0:    byte_data_s = HEADER;
      3'd1:    byte_data_s = {1'b0, snap_r.score};
      3'd2:    byte_data_s = {1'b0, snap_r.bullets};
      3'd3:    byte_data_s = {snap_r.phase, 3'b000, snap_r.magazine};
`ifdef SCORE_LINK_CHECKSUM_EN
      3'd4:    byte_data_s = link_checksum({1'b0, snap_r.score},
                                           {1'b0, snap_r.bullets},
                                           {snap_r.phase, 3'b000, snap_r.magazine});
`endif
      default: byte_data_s = HEADER;
    endcase
  end

  // Frame state, snapshot, last-sent record and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      byte_idx_r   <= 3'd0;
      snap_r       <= '0;
      last_sent_r  <= '0;
      force_send_r <= 1'b1;
      busy_r       <= 1'b0;
      frame_sent_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      frame_sent_r <= frame_end_s;
      if (state_r == ST_LOAD) begin
        snap_r       <= cur_s;
        last_sent_r  <= cur_s;
        force_send_r <= 1'b0;
        busy_r       <= 1'b1;
      end else if (frame_end_s) begin
        busy_r <= 1'b0;
      end
      if (start_s) begin
        byte_idx_r <= byte_sel_s;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx_byte (
    .clk   (clk),
    .rst   (rst),
    .start (start_s),
    .data  (byte_data_s),
    .tx    (tx_s),
    .done  (byte_done_s)
  );

  assign tx         = tx_s;
  assign busy       = busy_r;
  assign frame_sent = frame_sent_r;

endmodule

// File: tb/tb_score_link_tx.sv
// Self-checking bench for score_link_tx with CLKS_PER_BIT = 4.
// A line monitor decodes UART bytes off `tx`; expected frames come from
// hand-written vectors and from a field-level model of the frame format.
module tb_score_link_tx;

  localparam int CPB = 4;
`ifdef SCORE_LINK_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int FRAME_CYC = NB * 10 * CPB;

  typedef logic [4:0][7:0] frame_t;
  typedef struct {
    logic [7:0] data;
    int         t0;
    logic       stop_ok;
  } rx_byte_t;
  typedef struct {
    logic [6:0] sc;
    logic [6:0] bl;
    logic [2:0] mg;
    logic       s;
    logic       g;
    logic       e;
    frame_t     exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] my_score = 7'd0;
  logic [6:0] bullets_left = 7'd0;
  logic [2:0] bullets_in_magazine = 3'd0;
  logic       start_screen_enable = 1'b0;
  logic       game_enable = 1'b0;
  logic       game_end_enable = 1'b0;
  logic       tx;
  logic       busy;
  logic       frame_sent;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  rx_byte_t rx_q[$];
  int       fs_q[$];
  int       rise_q[$];
  int       fall_q[$];
  logic       in_byte = 1'b0;
  int         bt0 = 0;
  logic [7:0] sh = 8'h00;
  logic       busy_prev = 1'b0;

  score_link_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .my_score            (my_score),
    .bullets_left        (bullets_left),
    .bullets_in_magazine (bullets_in_magazine),
    .start_screen_enable (start_screen_enable),
    .game_enable         (game_enable),
    .game_end_enable     (game_end_enable),
    .tx                  (tx),
    .busy                (busy),
    .frame_sent          (frame_sent)
  );

  always #5 clk = ~clk;

  // cycle number: value of cyc during the cycle that follows each rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // line monitor: UART decode (mid-bit sampling), busy edges, frame_sent pulses
  always @(negedge clk) begin
    if (rst) begin
      in_byte   <= 1'b0;
      busy_prev <= 1'b0;
    end else begin
      busy_prev <= busy;
      if (busy && !busy_prev) rise_q.push_back(cyc);
      if (!busy && busy_prev) fall_q.push_back(cyc);
      if (frame_sent) fs_q.push_back(cyc);
      if (!in_byte) begin
        if (tx == 1'b0) begin
          in_byte <= 1'b1;
          bt0     <= cyc;
        end
      end else begin
        if (((cyc - bt0) % CPB == CPB / 2) && ((cyc - bt0) / CPB >= 1) && ((cyc - bt0) / CPB <= 8))
          sh[(cyc - bt0) / CPB - 1] <= tx;
        if ((cyc - bt0) == 9 * CPB + CPB / 2)
          rx_q.push_back(rx_byte_t'{data: sh, t0: bt0, stop_ok: tx});
        if ((cyc - bt0) == 10 * CPB - 1)
          in_byte <= 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic frame_t mk(input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3,
                                input logic [7:0] b4);
    frame_t f;
    f[0] = b0; f[1] = b1; f[2] = b2; f[3] = b3; f[4] = b4;
    return f;
  endfunction

  // reference model: frame bytes from the field rules
  function automatic frame_t model_frame(input int sc, input int bl, input int mg,
                                         input bit s, input bit g, input bit e);
    int ph;
    frame_t f;
    if (e) ph = 2;
    else if (g) ph = 1;
    else ph = 0;
    f[0] = 8'hA5;
    f[1] = 8'(sc);
    f[2] = 8'(bl);
    f[3] = 8'(ph * 64 + mg);
    f[4] = f[1] ^ f[2] ^ f[3];
    return f;
  endfunction

  // the value that decides whether a new frame is owed
  function automatic int model_key(input int sc, input int bl, input int mg,
                                   input bit s, input bit g, input bit e);
    int ph;
    if (e) ph = 2;
    else if (g) ph = 1;
    else ph = 0;
    return ((ph * 128 + sc) * 128 + bl) * 8 + mg;
  endfunction

  task automatic set_in(input int sc, input int bl, input int mg,
                        input bit s, input bit g, input bit e, output int n);
    @(posedge clk); #1;
    my_score = 7'(sc); bullets_left = 7'(bl); bullets_in_magazine = 3'(mg);
    start_screen_enable = s; game_enable = g; game_end_enable = e;
    n = cyc;
  endtask

  task automatic flush();
    rx_q.delete(); fs_q.delete(); rise_q.delete(); fall_q.delete();
  endtask

  task automatic get_frame(input frame_t exp, input int exp_t0, input string name, output int t0);
    rx_byte_t b;
    int k;
    t0 = -1;
    k = 0;
    while (rx_q.size() < NB && k < FRAME_CYC + 60) begin @(negedge clk); k++; end
    if (rx_q.size() < NB) begin
      chk({name, "_bytes_timeout"}, rx_q.size(), NB);
      flush();
      return;
    end
    for (int i = 0; i < NB; i++) begin
      b = rx_q.pop_front();
      if (i == 0) t0 = b.t0;
      chk($sformatf("%s_b%0d", name, i), b.data, exp[i]);
      chk($sformatf("%s_b%0d_stop", name, i), b.stop_ok, 1);
      if (i > 0) chk($sformatf("%s_b%0d_time", name, i), b.t0, t0 + i * 10 * CPB);
    end
    if (exp_t0 >= 0) chk({name, "_start_cycle"}, t0, exp_t0);
    k = 0;
    while (fs_q.size() == 0 && k < 20) begin @(negedge clk); k++; end
    if (fs_q.size() == 0) chk({name, "_frame_sent_missing"}, 0, 1);
    else chk({name, "_frame_sent_cycle"}, fs_q.pop_front(), t0 + FRAME_CYC);
    if (rise_q.size() == 0) chk({name, "_busy_rise_missing"}, 0, 1);
    else chk({name, "_busy_rise"}, rise_q.pop_front(), t0);
    if (fall_q.size() == 0) chk({name, "_busy_fall_missing"}, 0, 1);
    else chk({name, "_busy_fall"}, fall_q.pop_front(), t0 + FRAME_CYC);
  endtask

  vec_t tbl[6];

  initial begin
    int r, n, t0, t1, bad, key, prev_key;
    int sc, bl, mg;
    bit s, g, e;

    tbl[0] = '{7'h12, 7'h34, 3'd1, 1'b0, 1'b1, 1'b0, mk(8'hA5, 8'h12, 8'h34, 8'h41, 8'h67)};
    tbl[1] = '{7'h07, 7'h09, 3'd2, 1'b0, 1'b1, 1'b1, mk(8'hA5, 8'h07, 8'h09, 8'h82, 8'h8C)};
    tbl[2] = '{7'h7F, 7'h7F, 3'd7, 1'b0, 1'b0, 1'b0, mk(8'hA5, 8'h7F, 8'h7F, 8'h07, 8'h07)};
    tbl[3] = '{7'h00, 7'h00, 3'd0, 1'b0, 1'b0, 1'b1, mk(8'hA5, 8'h00, 8'h00, 8'h80, 8'h80)};
    tbl[4] = '{7'h55, 7'h2A, 3'd5, 1'b1, 1'b0, 1'b1, mk(8'hA5, 8'h55, 8'h2A, 8'h85, 8'hFA)};
    tbl[5] = '{7'h01, 7'h00, 3'd0, 1'b1, 1'b0, 1'b0, mk(8'hA5, 8'h01, 8'h00, 8'h00, 8'h01)};

    // reset state and announce frame
    rst = 1'b1;
    my_score = 7'd0; bullets_left = 7'd20; bullets_in_magazine = 3'd3;
    start_screen_enable = 1'b1; game_enable = 1'b0; game_end_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_frame_sent", frame_sent, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    r = cyc;
    get_frame(mk(8'hA5, 8'h00, 8'h14, 8'h03, 8'h17), r + 2, "announce", t0);

    // stable inputs: line stays quiet
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("idle_quiet_samples_bad", bad, 0);
    chk("idle_no_bytes", rx_q.size(), 0);

    // score change mid-frame: frame in flight keeps 05, next frame 3 cycles later
    set_in(5, 20, 3, 1'b1, 1'b1, 1'b0, n);
    while (rx_q.size() < 1 && cyc < n + FRAME_CYC) @(negedge clk);
    set_in(6, 20, 3, 1'b1, 1'b1, 1'b0, t1);
    get_frame(mk(8'hA5, 8'h05, 8'h14, 8'h43, 8'h52), n + 2, "midchg_first", t0);
    get_frame(mk(8'hA5, 8'h06, 8'h14, 8'h43, 8'h51), t0 + FRAME_CYC + 3, "midchg_second", t1);

    // reset pulse during byte B2, then a full announce frame
    repeat (3) @(negedge clk);
    set_in(9, 20, 3, 1'b1, 1'b1, 1'b0, n);
    while (rx_q.size() < 2 && cyc < n + FRAME_CYC) @(negedge clk);
    repeat (8) @(negedge clk);
    flush();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    r = cyc;
    @(negedge clk);
    chk("midreset_tx_high", tx, 1);
    chk("midreset_busy_low", busy, 0);
    flush();
    get_frame(mk(8'hA5, 8'h09, 8'h14, 8'h43, 8'h5E), r + 2, "midreset_announce", t0);

    // table vectors: phase priority, extremes, checksum values
    for (int i = 0; i < 6; i++) begin
      repeat (2) @(negedge clk);
      set_in(tbl[i].sc, tbl[i].bl, tbl[i].mg, tbl[i].s, tbl[i].g, tbl[i].e, n);
      get_frame(tbl[i].exp, n + 2, $sformatf("vec%0d", i), t0);
    end

    // randomized against the field-level model
    prev_key = model_key(tbl[5].sc, tbl[5].bl, tbl[5].mg, tbl[5].s, tbl[5].g, tbl[5].e);
    sc = tbl[5].sc; bl = tbl[5].bl; mg = tbl[5].mg;
    s = tbl[5].s; g = tbl[5].g; e = tbl[5].e;
    for (int i = 0; i < 20; i++) begin
      repeat (2) @(negedge clk);
      if ($urandom_range(3, 0) != 0) begin
        sc = $urandom_range(127, 0); bl = $urandom_range(127, 0); mg = $urandom_range(7, 0);
        s = 1'($urandom_range(1, 0)); g = 1'($urandom_range(1, 0)); e = 1'($urandom_range(1, 0));
      end
      set_in(sc, bl, mg, s, g, e, n);
      key = model_key(sc, bl, mg, s, g, e);
      if (key == prev_key) begin
        repeat (FRAME_CYC + 20) @(negedge clk);
        chk($sformatf("rand%0d_silent_bytes", i), rx_q.size(), 0);
        chk($sformatf("rand%0d_silent_busy", i), rise_q.size(), 0);
        flush();
      end else begin
        get_frame(model_frame(sc, bl, mg, s, g, e), n + 2, $sformatf("rand%0d", i), t0);
      end
      prev_key = key;
    end

    repeat (10) @(negedge clk);
    chk("final_no_stray_frame_sent", fs_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
